// File: rtl/ring_scan_display_pkg.sv
// Shared constants for the ring-scanned 7-segment display: segment patterns,
// controller state encoding and the default digit count.
package scan_pkg;

    localparam int N_DIG_DEF = 4;

    // Segment patterns, bit0 = segment a, active-high logical form
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef logic [1:0] state_t;

    localparam state_t SYNC  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t FAULT = 2'd2;

endpackage

// File: rtl/ring_scan_display_bcd_to_seg.sv
// Combinational BCD to 7-segment decoder; codes 10-15 render as a dash.
module bcd_to_seg
    import scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/ring_scan_display.sv
// Multiplexes a staged BCD value onto a shared 7-segment bus, one digit per
// ring phase. Optional build macro: LEADING_ZERO_BLANK_EN.
//
// state | meaning
// SYNC  | waiting for the first ring frame start, outputs blank
// RUN   | scanning digits, ring checked every cycle
// FAULT | ring sequence error seen, outputs blank until clr
module ring_scan_display
    import scan_pkg::*;
#(
    parameter int N_DIG   = N_DIG_DEF,
    parameter bit SEG_POL = 1'b0
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [N_DIG-1:0]   ring,
    input  logic               in_valid,
    input  logic [4*N_DIG-1:0] in_data,
    output logic               in_ready,
    output logic [6:0]         seg,
    output logic [N_DIG-1:0]   an,
    output logic               fault,
    output logic               frame_done
);

    localparam logic [N_DIG-1:0] PHASE_FIRST = N_DIG'(1);
    localparam logic [N_DIG-1:0] PHASE_LAST  = N_DIG'(1) << (N_DIG - 1);
    localparam logic [N_DIG-1:0] AN_OFF      = {N_DIG{SEG_POL}};
    localparam logic [6:0]       SEG_OFF     = {7{SEG_POL}};

    state_t             state;
    logic               stage_full;
    logic [4*N_DIG-1:0] stage;
    logic [4*N_DIG-1:0] shadow;
    logic [4*N_DIG-1:0] shadow_view;
    logic [N_DIG-1:0]   prev_ring;
    logic [N_DIG-1:0]   ring_rot;
    logic               frame_start;
    logic               promote;
    logic               accept;
    logic               ring_legal;
    logic               wrap;
    logic [3:0]         digit;
    logic [6:0]         dec_seg;
    logic [6:0]         seg_next;
    logic [N_DIG-1:0]   an_r;
    logic [6:0]         seg_r;
    logic               fault_r;
    logic               frame_done_r;

    assign frame_start = (ring == PHASE_FIRST) && (ring != prev_ring);
    assign promote     = frame_start && stage_full;
    assign accept      = in_valid && !stage_full;
    assign ring_rot    = {prev_ring[N_DIG-2:0], prev_ring[N_DIG-1]};
    assign ring_legal  = (ring == prev_ring) || (ring == ring_rot);
    assign wrap        = (prev_ring == PHASE_LAST) && (ring == PHASE_FIRST);

    // Digit 0 of a new frame must already come from the promoted value
    assign shadow_view = promote ? stage : shadow;

    always_comb begin
        digit = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (ring[i]) digit = digit | shadow_view[4*i +: 4];
        end
    end

    bcd_to_seg u_dec (
        .bcd (digit),
        .seg (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [N_DIG-1:0] lz_blank;
    logic             upper_zero;

    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int i = N_DIG - 1; i > 0; i--) begin
            upper_zero  = upper_zero && (shadow_view[4*i +: 4] == 4'd0);
            lz_blank[i] = upper_zero;
        end
        seg_next = (|(ring & lz_blank)) ? SEG_BLANK : dec_seg;
    end
`else
    assign seg_next = dec_seg;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= SYNC;
            stage_full   <= 1'b0;
            stage        <= '0;
            shadow       <= '0;
            prev_ring    <= '0;
            an_r         <= AN_OFF;
            seg_r        <= SEG_OFF;
            fault_r      <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            prev_ring <= ring;
            if (promote) begin
                shadow     <= stage;
                stage_full <= 1'b0;
            end else if (accept) begin
                stage      <= in_data;
                stage_full <= 1'b1;
            end

            an_r         <= AN_OFF;
            seg_r        <= SEG_OFF;
            frame_done_r <= 1'b0;
            case (state)
                SYNC: begin
                    if (frame_start) state <= RUN;
                end
                RUN: begin
                    if (ring_legal) begin
                        an_r         <= ring ^ AN_OFF;
                        seg_r        <= seg_next ^ SEG_OFF;
                        frame_done_r <= wrap;
                    end else begin
                        state   <= FAULT;
                        fault_r <= 1'b1;
                    end
                end
                FAULT: begin
                    fault_r <= 1'b1;
                end
                default: begin
                    state   <= FAULT;
                    fault_r <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = !stage_full;
    assign seg        = seg_r;
    assign an         = an_r;
    assign fault      = fault_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_ring_scan_display.sv
// Directed bench for ring_scan_display: data path, handshake, ring faults,
// non-BCD digits and mid-frame reset, with hand-computed expectations.
module tb_ring_scan_display;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        clr;
    logic [3:0]  ring;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        fault;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_1234 [4];
    logic [6:0] seg_5678 [4];
    logic [3:0] r;

    ring_scan_display #(.N_DIG(4), .SEG_POL(1'b0)) dut (
        .clk        (clk),
        .clr        (clr),
        .ring       (ring),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .seg        (seg),
        .an         (an),
        .fault      (fault),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [3:0] rv);
        ring = rv;
        tick();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected segments for digit idx of value v when leading-zero blanking is built in
    function automatic logic [6:0] lzb(input logic [15:0] v, input int idx, input logic [6:0] s);
        if (LZB && idx > 0 && (v >> (4 * idx)) == 16'h0) return 7'h00;
        return s;
    endfunction

    initial begin
        seg_1234 = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        seg_5678 = '{7'h7F, 7'h07, 7'h7D, 7'h6D};

        clr = 1'b1; ring = 4'b0001; in_valid = 1'b0; in_data = 16'h0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_an", an, 0);
        chk("rst_seg", seg, 0);
        chk("rst_fault", fault, 0);
        chk("rst_frame_done", frame_done, 0);

        // data path: accept coincides with the first frame start
        clr = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
        cyc(4'b0001);
        in_valid = 1'b0;
        chk("dp_ready_low", in_ready, 0);
        chk("dp_sync_blank", an, 0);
        cyc(4'b0010);
        chk("dp_f1_an", an, 4'b0010);
        chk("dp_f1_seg", seg, lzb(16'h0, 1, 7'h3F));
        cyc(4'b0100);
        cyc(4'b1000);
        chk("dp_f1_fd", frame_done, 0);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) begin
                r = 4'b0001 << i;
                cyc(r);
                chk("dp_an", an, r);
                chk("dp_seg", seg, seg_1234[i]);
                chk("dp_fd", frame_done, (i == 0) ? 16'd1 : 16'd0);
                if (f == 0 && i == 0) chk("dp_ready_back", in_ready, 1);
            end
        end

        // handshake
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cyc(4'b0001);
        in_valid = 1'b1; in_data = 16'h1234;
        cyc(4'b0010);
        chk("hs_ready_drop", in_ready, 0);
        in_data = 16'h5678;
        cyc(4'b0100);
        chk("hs_ready_hold1", in_ready, 0);
        cyc(4'b1000);
        chk("hs_ready_hold2", in_ready, 0);
        cyc(4'b0001);
        chk("hs_ready_rise", in_ready, 1);
        chk("hs_seg_d0", seg, 7'h66);
        cyc(4'b0010);
        in_valid = 1'b0;
        chk("hs_ready_second", in_ready, 0);
        chk("hs_seg_d1", seg, 7'h4F);
        cyc(4'b0100);
        chk("hs_seg_d2", seg, 7'h5B);
        cyc(4'b1000);
        chk("hs_seg_d3", seg, 7'h06);
        for (int i = 0; i < 4; i++) begin
            r = 4'b0001 << i;
            cyc(r);
            chk("hs_an_5678", an, r);
            chk("hs_seg_5678", seg, seg_5678[i]);
            chk("hs_fd_5678", frame_done, (i == 0) ? 16'd1 : 16'd0);
        end

        // non-BCD digit, accepted on a frame start while the stage is empty
        in_valid = 1'b1; in_data = 16'h00A0;
        cyc(4'b0001);
        in_valid = 1'b0;
        chk("nb_old_frame", seg, 7'h7F);
        chk("nb_staged", in_ready, 0);
        cyc(4'b0010);
        cyc(4'b0100);
        cyc(4'b1000);
        cyc(4'b0001);
        chk("nb_d0", seg, 7'h3F);
        cyc(4'b0010);
        chk("nb_d1_dash", seg, 7'h40);
        cyc(4'b0100);
        chk("nb_d2", seg, lzb(16'h00A0, 2, 7'h3F));
        chk("nb_d2_an", an, 4'b0100);
        cyc(4'b1000);
        chk("nb_d3", seg, lzb(16'h00A0, 3, 7'h3F));

        // phase held for three cycles is legal
        cyc(4'b0001);
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0010);
            chk("hold_an", an, 4'b0010);
            chk("hold_seg", seg, 7'h40);
            chk("hold_fault", fault, 0);
        end

        // illegal multi-hot code
        cyc(4'b0011);
        chk("ill_fault", fault, 1);
        chk("ill_an", an, 0);
        chk("ill_seg", seg, 0);
        cyc(4'b0100);
        cyc(4'b1000);
        cyc(4'b0001);
        chk("ill_sticky_fault", fault, 1);
        chk("ill_sticky_an", an, 0);
        chk("ill_sticky_seg", seg, 0);
        chk("ill_sticky_fd", frame_done, 0);

        clr = 1'b1;
        cyc(4'b0001);
        clr = 1'b0;
        chk("clr_fault", fault, 0);
        chk("clr_ready", in_ready, 1);

        // skipped phase
        cyc(4'b0001);
        cyc(4'b0100);
        chk("skip_fault", fault, 1);
        chk("skip_an", an, 0);

        clr = 1'b1;
        cyc(4'b0001);
        clr = 1'b0;

        // reset mid-frame with the stage full
        cyc(4'b0001);
        in_valid = 1'b1; in_data = 16'h9999;
        cyc(4'b0010);
        in_valid = 1'b0;
        chk("mr_ready_low", in_ready, 0);
        chk("mr_an", an, 4'b0010);
        chk("mr_seg", seg, lzb(16'h0, 1, 7'h3F));
        clr = 1'b1;
        cyc(4'b0100);
        clr = 1'b0;
        chk("mr_ready", in_ready, 1);
        chk("mr_an_blank", an, 0);
        chk("mr_seg_blank", seg, 0);
        chk("mr_fault", fault, 0);
        cyc(4'b1000);
        chk("mr_still_blank", an, 0);
        cyc(4'b0001);
        cyc(4'b0010);
        chk("mr_resume_an", an, 4'b0010);
        chk("mr_resume_seg", seg, lzb(16'h0, 1, 7'h3F));
        cyc(4'b0100);
        chk("mr_resume_seg2", seg, lzb(16'h0, 2, 7'h3F));
        cyc(4'b1000);
        cyc(4'b0001);
        chk("mr_wrap_an", an, 4'b0001);
        chk("mr_wrap_seg", seg, 7'h3F);
        chk("mr_wrap_fd", frame_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_scan_display.md
Name: ring_scan_display

Overview:
- Downstream consumer of the 4-bit one-hot ring counter output.
- Uses each ring phase as a digit-select strobe to time-multiplex a 4-digit BCD value onto one shared 7-segment bus.
- Input value arrives over a valid/ready handshake into a one-entry staging register. The staged value is promoted to the displayed shadow only at a frame boundary, so a frame never mixes old and new digits.
- Monitors the ring for illegal codes and skipped phases, and latches a sticky fault.

Parameters:
- N_DIG, 4: digit count; equals ring width.
- SEG_POL, 0: output polarity. 0 = active-high. 1 = seg and an are both inverted at the output register.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous, active-high reset.
- ring  in  N_DIG  one-hot phase from the ring counter (bit0 = digit0).
- in_valid  in  1  source has a value.
- in_data  in  4*N_DIG  BCD digits; digit0 at [3:0].
- in_ready  out  1  staging register empty.
- seg  out  7  segments a..g; bit0 = a.
- an  out  N_DIG  digit enable.
- fault  out  1  sticky ring-sequence error.
- frame_done  out  1  one-cycle pulse per completed frame.

Behaviour:
- Reset (clr=1 at a clock edge) forces all of the following, regardless of any other input in that cycle:
  - stage empty, shadow = 0, prev_ring = 0, state = SYNC
  - in_ready = 1, fault = 0, frame_done = 0
  - an = all off, seg = all off (logical zero before SEG_POL inversion)
- Handshake:
  - in_ready = ~stage_full.
  - Accept when in_valid & in_ready; stage_full is set on the next edge.
  - in_data is ignored while in_ready = 0.
- Frame start is defined as ring == one-hot bit0 and ring != prev_ring.
  - At frame start with stage_full: shadow <= stage, stage_full cleared, in_ready = 1 the following cycle.
  - Accept coinciding with frame start while the stage is empty: data lands in the stage only and is shown from the next frame.
- States:
  - SYNC: outputs blank. Goes to RUN on the first frame start.
  - RUN: each cycle, ring must equal prev_ring (hold) or rotate-left(prev_ring). Anything else goes to FAULT. This includes zero, multi-hot and skipped phases.
  - FAULT: fault = 1, outputs blank. Exit only via clr.
- Output timing:
  - Registered, 1-cycle latency: in RUN with a legal ring at cycle t, at t+1 an = ring and seg = decode(shadow digit selected by ring).
  - The fault check is itself registered: an illegal ring at t gives fault = 1 and blank outputs at t+1.
- Decode:
  - 0-9: standard patterns (0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66, 5 = 0x6D, 6 = 0x7D, 7 = 0x07, 8 = 0x7F, 9 = 0x6F).
  - 10-15: dash, 0x40.
- frame_done: pulses at t+1 when RUN observes the transition 1000 -> 0001 at t.
  - The first frame start after SYNC does not pulse.
- clr mid-frame: stage contents are discarded; the block returns to SYNC.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: digits above the most-significant nonzero digit of shadow are blank (seg = off, an still asserted). Digit0 is always shown, so a value of 0 displays "0".
- Undefined: all digits are shown, including leading zeros.

Decomposition:
- Package scan_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK
  - state encoding SYNC/RUN/FAULT
  - default N_DIG
- One sub-module, bcd_to_seg: combinational 4-bit to 7-segment decoder. It is instantiated once and fed the ring-selected digit.

Test Plan:
- Data path: clr 2 cycles; ring runs 0001->0010->0100->1000 repeatedly; in_data = 0x1234 accepted.
  - From the second frame: an 0001/0010/0100/1000 paired with seg 0x66/0x4F/0x5B/0x06.
  - frame_done pulses on each wrap.
- Handshake: 0x1234 valid mid-frame, then 0x5678 held valid.
  - in_ready drops after the first accept and rises the cycle after the next frame start.
  - 0x5678 is accepted then and displayed one frame after 0x1234.
- Illegal code: ring = 0011 in RUN.
  - Next cycle: fault = 1, an = 0, seg = 0.
  - Remains so after a legal ring resumes, until clr.
- Skipped phase: ring 0001 -> 0100 gives fault = 1. Ring held at 0010 for 3 cycles gives no fault, with outputs held.
- Non-BCD digit: in_data = 0x00A0 gives seg = 0x40 during ring = 0010.
  - With LEADING_ZERO_BLANK_EN: digits 3..2 blank, digit0 shows 0x3F.
- Reset mid-operation: clr asserted with stage full mid-frame.
  - Next cycle: in_ready = 1, outputs blank, fault = 0.
  - Display stays blank until a ring 0001 frame start, then shows 0000 (0x3F on every digit).
